// File: rtl/dom_indep_d1_sharing_if.sv
// Operand, seed and share bus between the sharing stage and its neighbours.
// The bench or upstream logic uses the master side; the sharing stage uses the slave side.
interface dom_indep_d1_sharing_if;
   logic        seed_valid;
   logic [31:0] seed;
   logic        in_valid;
   logic        in_a;
   logic        in_b;
   logic        in_ready;
   logic [1:0]  port_a;
   logic [1:0]  port_b;
   logic        port_r;
   logic        out_valid;
   logic        c_valid;
   logic        busy;

   modport master (
      output seed_valid, seed, in_valid, in_a, in_b,
      input  in_ready, port_a, port_b, port_r, out_valid, c_valid, busy
   );

   modport slave (
      input  seed_valid, seed, in_valid, in_a, in_b,
      output in_ready, port_a, port_b, port_r, out_valid, c_valid, busy
   );
endinterface

// File: rtl/dom_indep_d1_sharing.sv
// First-order sharing and randomness stage feeding a DOM-independent AND gadget.
// Optional LFSR warm-up after reset/reseed is enabled by defining DOM_SHARE_WARMUP_EN.
module dom_indep_d1_sharing #(
   parameter logic [31:0] SEED   = 32'hACE1_2468,
   parameter int          WARMUP = 16
) (
   input logic clk,
   input logic rst,
   dom_indep_d1_sharing_if.slave bus
);

   if (WARMUP < 1 || WARMUP > 255) begin : g_bad_warmup
      $error("WARMUP must lie in 1..255");
   end

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   logic [31:0] lfsr_q, lfsr_d;
   logic [31:0] s1, s2, s3;
   logic        m_a, m_b, r;
   logic [1:0]  port_a_q, port_a_d;
   logic [1:0]  port_b_q, port_b_d;
   logic        port_r_q, port_r_d;
   logic        out_valid_q, out_valid_d;
   logic        c_valid_q, c_valid_d;
   logic        in_ready, busy, run, accept;

`ifdef DOM_SHARE_WARMUP_EN
   typedef enum logic {ST_WARMUP, ST_RUN} state_t;
   localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_WARMUP;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A reseed restarts warm-up from either state; the counter parks once it hits WARMUP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.seed_valid) begin
         state_d = ST_WARMUP;
         cnt_d   = 8'd0;
      end else if (state_q == ST_WARMUP) begin
         if (cnt_q == WARMUP_CNT) state_d = ST_RUN;
         else                     cnt_d   = cnt_q + 8'd1;
      end
   end

   always_comb begin
      run      = (state_q == ST_RUN);
      busy     = (state_q == ST_WARMUP);
      in_ready = run && !bus.seed_valid;
   end
`else
   always_comb begin
      run      = 1'b1;
      busy     = 1'b0;
      in_ready = !bus.seed_valid;
   end
`endif

   // Three unrolled steps give the two mask bits and the gadget refresh bit.
   always_comb begin
      s1  = lfsr_step(lfsr_q);
      s2  = lfsr_step(s1);
      s3  = lfsr_step(s2);
      m_a = s1[0];
      m_b = s2[0];
      r   = s3[0];
   end

   always_comb begin
      accept      = bus.in_valid && in_ready;
      lfsr_d      = s3;
      if (bus.seed_valid) lfsr_d = (bus.seed == 32'd0) ? SEED : bus.seed;
      port_a_d    = port_a_q;
      port_b_d    = port_b_q;
      if (accept) begin
         port_a_d = {bus.in_a ^ m_a, m_a};
         port_b_d = {bus.in_b ^ m_b, m_b};
      end
      out_valid_d = accept;
      c_valid_d   = out_valid_q;
      port_r_d    = run ? r : port_r_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q      <= SEED;
         port_a_q    <= 2'b00;
         port_b_q    <= 2'b00;
         port_r_q    <= 1'b0;
         out_valid_q <= 1'b0;
         c_valid_q   <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_d;
         port_a_q    <= port_a_d;
         port_b_q    <= port_b_d;
         port_r_q    <= port_r_d;
         out_valid_q <= out_valid_d;
         c_valid_q   <= c_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.busy      = busy;
   assign bus.port_a    = port_a_q;
   assign bus.port_b    = port_b_q;
   assign bus.port_r    = port_r_q;
   assign bus.out_valid = out_valid_q;
   assign bus.c_valid   = c_valid_q;

endmodule
